// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: shares the single-port config register bank between the SPI and core requesters
module reg_access_arbiter #(
  parameter int RD_LAT         = 1,
  parameter int MAX_SPI_STREAK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_req,
  input  logic       spi_we,
  input  logic [6:0] spi_addr,
  input  logic [7:0] spi_wdata,
  output logic       spi_gnt,
  output logic       spi_rvalid,
  output logic [7:0] spi_rdata,
  input  logic       core_req,
  input  logic       core_we,
  input  logic [6:0] core_addr,
  input  logic [7:0] core_wdata,
  output logic       core_gnt,
  output logic       core_rvalid,
  output logic [7:0] core_rdata,
  output logic       mem_en,
  output logic       mem_we,
  output logic [6:0] mem_addr,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata
);
  localparam int SW = $clog2(MAX_SPI_STREAK + 1);
  localparam int CW = $clog2(RD_LAT + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;
  state_t        state, state_d;
  logic [SW-1:0] streak, streak_d;
  logic [CW-1:0] cnt, cnt_d;
  logic          win_core, pick_core, issue, rd_done;
  // core wins when alone or once SPI has used up its streak allowance
  assign pick_core = core_req && (!spi_req || streak == SW'(MAX_SPI_STREAK));
  assign issue     = state == IDLE && (spi_req || core_req);
  assign rd_done   = state == RD_WAIT && cnt == CW'(RD_LAT);
  always_comb begin
    state_d = state == IDLE  ? (issue ? ISSUE : IDLE) :
              state == ISSUE ? (mem_we ? IDLE : RD_WAIT) :
              rd_done        ? IDLE : RD_WAIT;
  end
  always_comb begin
    streak_d = state != IDLE ? streak : (core_req && !pick_core) ? streak + 1'b1 : '0;
    cnt_d    = state == RD_WAIT ? cnt + 1'b1 : CW'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      streak      <= '0;
      cnt         <= '0;
      win_core    <= 1'b0;
      spi_gnt     <= 1'b0;
      spi_rvalid  <= 1'b0;
      spi_rdata   <= '0;
      core_gnt    <= 1'b0;
      core_rvalid <= 1'b0;
      core_rdata  <= '0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_d;
      streak      <= streak_d;
      cnt         <= cnt_d;
      mem_en      <= issue;
      spi_gnt     <= issue && !pick_core;
      core_gnt    <= issue && pick_core;
      spi_rvalid  <= rd_done && !win_core;
      core_rvalid <= rd_done && win_core;
      if (issue) begin
        win_core  <= pick_core;
        mem_we    <= pick_core ? core_we : spi_we;
        mem_addr  <= pick_core ? core_addr : spi_addr;
        mem_wdata <= pick_core ? core_wdata : spi_wdata;
      end
      if (rd_done && !win_core) spi_rdata <= mem_rdata;
      if (rd_done && win_core) core_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: scenario tasks against two builds (RD_LAT=1/MAX=3 and RD_LAT=3/MAX=4)
module tb_reg_access_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  logic       spi_req = 1'b0, spi_we = 1'b0, core_req = 1'b0, core_we = 1'b0;
  logic [6:0] spi_addr = '0, core_addr = '0;
  logic [7:0] spi_wdata = '0, core_wdata = '0;
  logic       a_spi_gnt, a_spi_rvalid, a_core_gnt, a_core_rvalid, a_mem_en, a_mem_we;
  logic [7:0] a_spi_rdata, a_core_rdata, a_mem_wdata, a_mem_rdata;
  logic [6:0] a_mem_addr;
  logic       b_spi_gnt, b_spi_rvalid, b_core_gnt, b_core_rvalid, b_mem_en, b_mem_we;
  logic [7:0] b_spi_rdata, b_core_rdata, b_mem_wdata, b_mem_rdata;
  logic [6:0] b_mem_addr;
  logic [7:0] a_pipe = 8'h00;
  logic [7:0] b_pipe [3];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         gnt_q [$];
  logic [7:0] rd_q [$];
  wire [36:0] a_outs = {a_spi_gnt, a_spi_rvalid, a_spi_rdata, a_core_gnt, a_core_rvalid, a_core_rdata,
                        a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata};
  wire [36:0] b_outs = {b_spi_gnt, b_spi_rvalid, b_spi_rdata, b_core_gnt, b_core_rvalid, b_core_rdata,
                        b_mem_en, b_mem_we, b_mem_addr, b_mem_wdata};
  reg_access_arbiter #(.RD_LAT(1), .MAX_SPI_STREAK(3)) u_a (
    .clk(clk), .rst(rst),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(a_spi_gnt), .spi_rvalid(a_spi_rvalid), .spi_rdata(a_spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(a_core_gnt), .core_rvalid(a_core_rvalid), .core_rdata(a_core_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata)
  );
  reg_access_arbiter #(.RD_LAT(3), .MAX_SPI_STREAK(4)) u_b (
    .clk(clk), .rst(rst),
    .spi_req(spi_req), .spi_we(spi_we), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
    .spi_gnt(b_spi_gnt), .spi_rvalid(b_spi_rvalid), .spi_rdata(b_spi_rdata),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(b_core_gnt), .core_rvalid(b_core_rvalid), .core_rdata(b_core_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata)
  );
  function automatic logic [7:0] bank(input logic [6:0] a);
    return a == 7'h10 ? 8'h3C : a == 7'h7F ? 8'hC3 : {1'b0, a} ^ 8'h5A;
  endfunction
  // bank models: data valid exactly RD_LAT cycles after mem_en, junk otherwise
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    a_pipe    <= a_mem_en ? bank(a_mem_addr) : 8'hEE;
    b_pipe[0] <= b_mem_en ? bank(b_mem_addr) : 8'hEE;
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign a_mem_rdata = a_pipe;
  assign b_mem_rdata = b_pipe[2];
  task automatic drive_spi(input bit req, input bit we, input logic [6:0] a, input logic [7:0] d);
    spi_req = req; spi_we = we; spi_addr = a; spi_wdata = d;
  endtask
  task automatic drive_core(input bit req, input bit we, input logic [6:0] a, input logic [7:0] d);
    core_req = req; core_we = we; core_addr = a; core_wdata = d;
  endtask
  task automatic wait_a_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = a_spi_gnt | a_core_gnt;
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (a_outs !== 37'd0) begin errors++; $display("FAIL reset_a got %h want 0", a_outs); end
    checks++;
    if (b_outs !== 37'd0) begin errors++; $display("FAIL reset_b got %h want 0", b_outs); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b0) begin errors++; $display("FAIL idle_no_req mem_en got %b want 0", a_mem_en); end
  endtask
  task automatic test_spi_write;
    bit rv = 1'b0;
    drive_spi(1, 1, 7'h05, 8'hA5);
    @(negedge clk);
    checks++;
    if ({a_spi_gnt, a_core_gnt} !== 2'b10) begin
      errors++; $display("FAIL wr_gnt got %b want 10", {a_spi_gnt, a_core_gnt});
    end
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {1'b1, 1'b1, 7'h05, 8'hA5}) begin
      errors++; $display("FAIL wr_bus got en%b we%b %h %h want 1 1 05 a5", a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata);
    end
    drive_spi(0, 0, 7'h00, 8'h00);
    @(negedge clk);
    checks++;
    if (a_mem_en !== 1'b0) begin errors++; $display("FAIL wr_one_shot mem_en got %b want 0", a_mem_en); end
    repeat (4) begin
      rv |= a_spi_rvalid | a_core_rvalid;
      @(negedge clk);
    end
    checks++;
    if (rv !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid got %b want 0", rv); end
  endtask
  task automatic test_core_read;
    drive_core(1, 0, 7'h10, 8'h00);
    gnt_q.push_back(1'b1);
    rd_q.push_back(8'h3C);
    @(negedge clk);
    checks++;
    if (a_core_gnt !== gnt_q.pop_front() || a_spi_gnt !== 1'b0) begin
      errors++; $display("FAIL rd_gnt got spi%b core%b want spi0 core1", a_spi_gnt, a_core_gnt);
    end
    checks++;
    if ({a_mem_en, a_mem_we, a_mem_addr} !== {1'b1, 1'b0, 7'h10}) begin
      errors++; $display("FAIL rd_bus got en%b we%b %h want 1 0 10", a_mem_en, a_mem_we, a_mem_addr);
    end
    drive_core(0, 0, 7'h00, 8'h00);
    @(negedge clk);
    checks++;
    if ({a_spi_rvalid, a_core_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rd_early got %b want 00", {a_spi_rvalid, a_core_rvalid});
    end
    @(negedge clk);
    checks++;
    if ({a_spi_rvalid, a_core_rvalid, a_core_rdata} !== {2'b01, rd_q.pop_front()}) begin
      errors++; $display("FAIL rd_data got rv%b%b %h want 01 3c", a_spi_rvalid, a_core_rvalid, a_core_rdata);
    end
    @(negedge clk);
    checks++;
    if ({a_core_rvalid, a_core_rdata} !== {1'b0, 8'h3C}) begin
      errors++; $display("FAIL rd_hold got rv%b %h want 0 3c", a_core_rvalid, a_core_rdata);
    end
  endtask
  task automatic test_streak_both;
    bit ok, exp;
    int prev = 0;
    for (int i = 0; i < 8; i++) gnt_q.push_back(i % 4 == 3);
    drive_spi(1, 1, 7'h01, 8'h11);
    drive_core(1, 1, 7'h02, 8'h22);
    for (int i = 0; i < 8; i++) begin
      wait_a_gnt(ok);
      exp = gnt_q.pop_front();
      checks++;
      if (!ok || a_core_gnt !== exp || a_mem_addr !== (exp ? 7'h02 : 7'h01)) begin
        errors++; $display("FAIL both_order#%0d got ok%b core%b addr %h want core%b", i, ok, a_core_gnt, a_mem_addr, exp);
      end
      if (i > 0) begin
        checks++;
        if (cyc - prev !== 2) begin errors++; $display("FAIL both_spacing#%0d got %0d want 2", i, cyc - prev); end
      end
      prev = cyc;
    end
    drive_spi(0, 0, 7'h00, 8'h00);
    drive_core(0, 0, 7'h00, 8'h00);
    repeat (2) @(negedge clk);
  endtask
  task automatic test_spi_stream;
    bit ok, exp;
    int prev = 0;
    drive_spi(1, 1, 7'h03, 8'h33);
    for (int i = 0; i < 4; i++) begin
      wait_a_gnt(ok);
      checks++;
      if (!ok || a_spi_gnt !== 1'b1 || (i > 0 && cyc - prev !== 2)) begin
        errors++; $display("FAIL stream#%0d got ok%b spi%b gap %0d want 1 1 2", i, ok, a_spi_gnt, cyc - prev);
      end
      prev = cyc;
    end
    drive_core(1, 1, 7'h04, 8'h44);
    for (int i = 0; i < 4; i++) gnt_q.push_back(i == 3);
    for (int i = 0; i < 4; i++) begin
      wait_a_gnt(ok);
      exp = gnt_q.pop_front();
      checks++;
      if (!ok || a_core_gnt !== exp) begin
        errors++; $display("FAIL stream_core#%0d got ok%b core%b want core%b", i, ok, a_core_gnt, exp);
      end
    end
    drive_spi(0, 0, 7'h00, 8'h00);
    drive_core(0, 0, 7'h00, 8'h00);
    repeat (2) @(negedge clk);
  endtask
  task automatic test_reset_mid_read;
    bit ok;
    bit rv = 1'b0;
    drive_spi(1, 0, 7'h20, 8'h00);
    rd_q.push_back(8'h7A);
    wait_a_gnt(ok);
    drive_spi(0, 0, 7'h00, 8'h00);
    repeat (2) @(negedge clk);
    checks++;
    if (!ok || {a_spi_rvalid, a_spi_rdata} !== {1'b1, rd_q.pop_front()}) begin
      errors++; $display("FAIL pre_rd got ok%b rv%b %h want 1 1 7a", ok, a_spi_rvalid, a_spi_rdata);
    end
    drive_spi(1, 0, 7'h33, 8'h00);
    wait_a_gnt(ok);
    drive_spi(0, 0, 7'h00, 8'h00);
    checks++;
    if (!ok || a_spi_gnt !== 1'b1) begin errors++; $display("FAIL abort_gnt got ok%b spi%b want 1 1", ok, a_spi_gnt); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (a_outs !== 37'd0) begin errors++; $display("FAIL abort_outs got %h want 0", a_outs); end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rv |= a_spi_rvalid | a_core_rvalid;
    end
    checks++;
    if (rv !== 1'b0) begin errors++; $display("FAIL abort_no_rvalid got %b want 0", rv); end
    drive_spi(1, 0, 7'h44, 8'h00);
    rd_q.push_back(8'h1E);
    wait_a_gnt(ok);
    drive_spi(0, 0, 7'h00, 8'h00);
    checks++;
    if (!ok || a_spi_gnt !== 1'b1) begin errors++; $display("FAIL post_rst_gnt got ok%b spi%b want 1 1", ok, a_spi_gnt); end
    repeat (2) @(negedge clk);
    checks++;
    if ({a_spi_rvalid, a_spi_rdata} !== {1'b1, rd_q.pop_front()}) begin
      errors++; $display("FAIL post_rst_rd got rv%b %h want 1 1e", a_spi_rvalid, a_spi_rdata);
    end
  endtask
  task automatic test_rd_lat3;
    bit ok = 1'b0;
    bit bad = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_spi(1, 0, 7'h7F, 8'h00);
    rd_q.push_back(8'hC3);
    for (int i = 0; i < 8 && !ok; i++) begin
      @(negedge clk);
      ok = b_spi_gnt;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL lat3_gnt got 0 want 1"); end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      bad |= b_core_rvalid | b_core_gnt;
      if (k < 4) bad |= b_spi_rvalid | b_spi_gnt;
      if (k == 4) begin
        checks++;
        if ({b_spi_rvalid, b_spi_gnt, b_spi_rdata} !== {2'b10, rd_q.pop_front()}) begin
          errors++; $display("FAIL lat3_rd got rv%b gnt%b %h want 1 0 c3", b_spi_rvalid, b_spi_gnt, b_spi_rdata);
        end
      end
      if (k == 5) begin
        checks++;
        if ({b_spi_gnt, b_spi_rvalid} !== 2'b10) begin
          errors++; $display("FAIL lat3_next_gnt got gnt%b rv%b want 1 0", b_spi_gnt, b_spi_rvalid);
        end
      end
    end
    drive_spi(0, 0, 7'h00, 8'h00);
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL lat3_quiet got %b want 0", bad); end
  endtask
  initial begin
    test_reset();
    test_spi_write();
    test_core_read();
    test_streak_both();
    test_spi_stream();
    test_reset_mid_read();
    test_rd_lat3();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
